// File: rtl/keypoint_collector_pkg.sv
// Shared types for the keypoint collector: FSM states,
// keypoint field widths and the packed FIFO entry.
package keypoint_collector_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 10;
  localparam int SCORE_W  = 8;
  localparam int ORIENT_W = 10;
  localparam int KP_W     = X_W + Y_W + SCORE_W + ORIENT_W;
  localparam int CNT_W    = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [SCORE_W-1:0]  score;
    logic [ORIENT_W-1:0] orient;
  } kp_t;

endpackage

// File: rtl/keypoint_collector_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Pointers carry one extra wrap bit to tell full from empty.
module kp_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 38
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_wr && !o_full)
        wr_ptr <= wr_ptr + 1'b1;
      if (i_rd && !o_empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr && !o_full && !i_flush && !i_rst)
      mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/keypoint_collector.sv
// Per-frame keypoint capture, cap/overflow tracking and FWFT drain.
// Optional score floor enabled by defining KP_MIN_SCORE_EN.
module keypoint_collector
  import keypoint_collector_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          MAX_KP    = 500,
  parameter logic [7:0]  MIN_SCORE = 8'd30
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_end,
  input  logic                i_flag,
  input  logic [X_W-1:0]      i_x,
  input  logic [Y_W-1:0]      i_y,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic [ORIENT_W-1:0] i_orient,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [X_W-1:0]      o_x,
  output logic [Y_W-1:0]      o_y,
  output logic [SCORE_W-1:0]  o_score,
  output logic [ORIENT_W-1:0] o_orient,
  output logic [CNT_W-1:0]    o_kp_count,
  output logic                o_overflow,
  output logic                o_capped,
  output logic                o_frame_done
);

  state_t state_q, state_d;

  logic wr_en, flush, set_ovf, set_cap, done_d;
  logic fifo_full, fifo_empty, score_ok, cap_hit;
  kp_t  in_kp, rd_kp, head_q;

  assign in_kp = '{x: i_x, y: i_y,
                   score: i_score, orient: i_orient};

`ifdef KP_MIN_SCORE_EN
  assign score_ok = (i_score >= MIN_SCORE);
`else
  // floor disabled: every flagged keypoint is eligible
  assign score_ok = ((MIN_SCORE & 8'h00) == 8'h00);
`endif

  assign cap_hit = (o_kp_count >= CNT_W'(MAX_KP));

  kp_fifo #(
    .DEPTH (DEPTH),
    .W     (KP_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (flush),
    .i_wr    (wr_en),
    .i_wdata (in_kp),
    .i_rd    (i_ready),
    .o_rdata (rd_kp),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    flush   = 1'b0;
    set_ovf = 1'b0;
    set_cap = 1'b0;
    done_d  = 1'b0;
    if (i_start) begin
      state_d = S_COLLECT;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_COLLECT: begin
          if (i_flag && score_ok) begin
            if (fifo_full)    set_ovf = 1'b1;
            else if (cap_hit) set_cap = 1'b1;
            else              wr_en   = 1'b1;
          end
          if (i_end) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_kp_count   <= '0;
      o_overflow   <= 1'b0;
      o_capped     <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= done_d;
      if (flush) begin
        o_kp_count <= '0;
        o_overflow <= 1'b0;
        o_capped   <= 1'b0;
      end else begin
        if (wr_en)   o_kp_count <= o_kp_count + 1'b1;
        if (set_ovf) o_overflow <= 1'b1;
        if (set_cap) o_capped   <= 1'b1;
      end
    end
  end

  // remembers the last presented head so outputs hold when empty
  always_ff @(posedge i_clk) begin
    if (i_rst)            head_q <= '0;
    else if (!fifo_empty) head_q <= rd_kp;
  end

  assign o_valid  = ~fifo_empty;
  assign o_x      = fifo_empty ? head_q.x      : rd_kp.x;
  assign o_y      = fifo_empty ? head_q.y      : rd_kp.y;
  assign o_score  = fifo_empty ? head_q.score  : rd_kp.score;
  assign o_orient = fifo_empty ? head_q.orient : rd_kp.orient;

endmodule

// File: tb/tb_keypoint_collector.sv
// Scoreboard bench for keypoint_collector (DEPTH=4, MAX_KP=5).
// Score-floor expectations follow KP_MIN_SCORE_EN.
module tb_keypoint_collector;
  import keypoint_collector_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_KP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, fend, flag, ready;
  logic [9:0] x, y, orient;
  logic [7:0] score;
  logic       o_valid, o_overflow, o_capped, o_frame_done;
  logic [9:0] o_x, o_y, o_orient, o_kp_count;
  logic [7:0] o_score;

  keypoint_collector #(
    .DEPTH     (DEPTH),
    .MAX_KP    (MAX_KP),
    .MIN_SCORE (8'd30)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_end        (fend),
    .i_flag       (flag),
    .i_x          (x),
    .i_y          (y),
    .i_score      (score),
    .i_orient     (orient),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_score      (o_score),
    .o_orient     (o_orient),
    .o_kp_count   (o_kp_count),
    .o_overflow   (o_overflow),
    .o_capped     (o_capped),
    .o_frame_done (o_frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  kp_t        exp_q[$];
  kp_t        m_last;
  logic [9:0] m_cnt;
  logic       m_ovf, m_cap, m_done;
  int         m_st;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit elig();
`ifdef KP_MIN_SCORE_EN
    return score >= 8'd30;
`else
    return 1'b1;
`endif
  endfunction

  // one clock: model the edge from pre-edge inputs, then check
  task automatic cyc();
    kp_t in_kp, head;
    int  sz;
    logic pop;
    @(negedge clk);
    sz   = exp_q.size();
    pop  = 1'b0;
    head = {o_x, o_y, o_score, o_orient};
    if (sz > 0) begin
      chk("head", head, exp_q[0]);
      pop = ready;
    end
    in_kp.x = x; in_kp.y = y;
    in_kp.score = score; in_kp.orient = orient;
    if (rst) begin
      exp_q.delete();
      m_cnt = '0; m_ovf = 0; m_cap = 0;
      m_done = 0; m_st = 0; m_last = '0;
    end else begin
      if (sz > 0) m_last = exp_q[0];
      m_done = 0;
      if (start) begin
        exp_q.delete();
        m_cnt = '0; m_ovf = 0; m_cap = 0; m_st = 1;
      end else begin
        if (pop) void'(exp_q.pop_front());
        case (m_st)
          1: begin
            if (flag && elig()) begin
              if (sz == DEPTH) m_ovf = 1;
              else if (m_cnt >= MAX_KP) m_cap = 1;
              else begin
                exp_q.push_back(in_kp);
                m_cnt++;
              end
            end
            if (fend) m_st = 2;
          end
          2: if (sz == 0) begin
            m_done = 1;
            m_st = 0;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("valid", o_valid, exp_q.size() > 0);
    chk("count", o_kp_count, m_cnt);
    chk("overflow", o_overflow, m_ovf);
    chk("capped", o_capped, m_cap);
    chk("done", o_frame_done, m_done);
    if (exp_q.size() == 0)
      chk("hold", {o_x, o_y, o_score, o_orient}, m_last);
  endtask

  task automatic idle(int n);
    start = 0; fend = 0; flag = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic kp(logic [9:0] xx, logic [9:0] yy,
                    logic [7:0] sc, logic [9:0] oo,
                    logic e);
    start = 0; flag = 1; fend = e;
    x = xx; y = yy; score = sc; orient = oo;
    cyc();
    flag = 0; fend = 0;
  endtask

  task automatic pulse_start();
    start = 1; fend = 0; flag = 0;
    cyc();
    start = 0;
  endtask

  task automatic pulse_end();
    start = 0; fend = 1; flag = 0;
    cyc();
    fend = 0;
  endtask

  initial begin
    rst = 1; start = 0; fend = 0; flag = 0; ready = 0;
    x = 0; y = 0; score = 0; orient = 0;
    cyc(); cyc();
    rst = 0;
    idle(2);

    // basic frame
    ready = 1;
    pulse_start();
    kp(10'd40, 10'd50, 8'd60, 10'd3, 1'b0);
    kp(10'd100, 10'd200, 8'd90, 10'd7, 1'b0);
    idle(2);
    pulse_end();
    idle(3);
    kp(10'd1, 10'd2, 8'd99, 10'd4, 1'b0);
    idle(1);

    // backpressure and overflow
    ready = 0;
    pulse_start();
    for (int i = 0; i < 6; i++)
      kp(10'(i + 5), 10'(i * 3), 8'(40 + i), 10'(i), 1'b0);
    idle(3);
    ready = 1;
    pulse_end();
    idle(6);

    // per-frame cap
    pulse_start();
    for (int i = 0; i < 7; i++)
      kp(10'(i + 300), 10'(i + 7), 8'(50 + i), 10'(i + 9), 1'b0);
    pulse_end();
    idle(4);

    // restart with two entries queued; flag on start dropped
    ready = 0;
    pulse_start();
    kp(10'd11, 10'd12, 8'd70, 10'd13, 1'b0);
    kp(10'd21, 10'd22, 8'd71, 10'd23, 1'b0);
    start = 1; flag = 1; x = 10'd99; score = 8'd80;
    cyc();
    start = 0; flag = 0;
    idle(2);
    ready = 1;
    pulse_end();
    idle(3);

    // flag together with end, then an empty frame
    pulse_start();
    kp(10'd500, 10'd600, 8'd77, 10'd700, 1'b1);
    idle(4);
    pulse_start();
    pulse_end();
    idle(3);

    // score floor boundary
    pulse_start();
    kp(10'd7, 10'd8, 8'd29, 10'd1, 1'b0);
    kp(10'd7, 10'd9, 8'd30, 10'd2, 1'b0);
    kp(10'd7, 10'd10, 8'd31, 10'd3, 1'b0);
    pulse_end();
    idle(4);

    // reset mid-frame with entries queued
    ready = 0;
    pulse_start();
    kp(10'd33, 10'd34, 8'd35, 10'd36, 1'b0);
    kp(10'd43, 10'd44, 8'd45, 10'd46, 1'b0);
    rst = 1;
    cyc();
    rst = 0;
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 39) == 0);
      fend   = ($urandom_range(0, 14) == 0);
      flag   = $urandom_range(0, 1);
      ready  = ($urandom_range(0, 2) != 0);
      x      = 10'($urandom);
      y      = 10'($urandom);
      score  = 8'($urandom_range(20, 40));
      orient = 10'($urandom);
      cyc();
    end
    ready = 1;
    pulse_end();
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypoint_collector.md
Name: keypoint_collector

Overview:
- Downstream consumer of the FAST detector output stream. It sits between the detector and the descriptor/matching stage.
- Captures flagged keypoints (X, Y, score, orientation) during one frame into a FIFO and drains them over a valid/ready interface.
- Counts accepted keypoints per frame, enforces a per-frame cap and reports drops.
- Signals frame completion once every keypoint of the frame has been consumed.

Parameters:
- DEPTH, 64, FIFO entries; power of 2, ≥ 4.
- MAX_KP, 500, max keypoints accepted per frame; must be ≤ 1023.
- MIN_SCORE, 8'd30, score floor; used only with KP_MIN_SCORE_EN.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  frame-start pulse (detector o_start).
- i_end  in  1  frame-end pulse (detector o_end).
- i_flag  in  1  keypoint valid this cycle.
- i_x  in  10  keypoint column.
- i_y  in  10  keypoint row.
- i_score  in  8  FAST/NMS score.
- i_orient  in  10  orientation code.
- o_valid  out  1  output entry available.
- i_ready  in  1  consumer accepts entry.
- o_x  out  10  head entry column.
- o_y  out  10  head entry row.
- o_score  out  8  head entry score.
- o_orient  out  10  head entry orientation.
- o_kp_count  out  10  keypoints accepted this frame.
- o_overflow  out  1  sticky: a keypoint was dropped because the FIFO was full.
- o_capped  out  1  sticky: a keypoint was dropped because MAX_KP was reached.
- o_frame_done  out  1  one-cycle pulse: frame ended and FIFO drained.

Behaviour:
- Reset values (i_rst high at an edge): state S_IDLE, FIFO empty, o_valid=0, o_x/o_y/o_score/o_orient=0, o_kp_count=0, o_overflow=0, o_capped=0, o_frame_done=0. Reset has priority over all other inputs, including mid-frame; a reset mid-frame discards the FIFO contents.
- Entry packing: {x, y, score, orient}, 38 bits.
- States:
  - S_IDLE:
    - i_flag and i_end are ignored.
    - i_start: go to S_COLLECT; clear o_kp_count, o_overflow and o_capped; flush the FIFO.
  - S_COLLECT:
    - A keypoint is accepted at the edge where i_flag=1.
    - Acceptance requires: FIFO not full (pre-edge occupancy), o_kp_count < MAX_KP, and, with KP_MIN_SCORE_EN, score ≥ MIN_SCORE.
    - An accepted keypoint is written to the FIFO and o_kp_count increments.
    - If the FIFO is full: drop, set o_overflow. A pop in the same cycle does not free space for the write.
    - Else if the cap is reached: drop, set o_capped.
    - i_end: go to S_DRAIN. An i_flag in the same cycle as i_end is still processed.
  - S_DRAIN:
    - No writes.
    - When the FIFO is empty, pulse o_frame_done for one cycle and go to S_IDLE.
    - i_end with an empty FIFO gives o_frame_done on the 2nd edge after i_end.
- i_start in S_COLLECT or S_DRAIN: restart the frame. FIFO flushed, counters and stickies cleared, state S_COLLECT, no o_frame_done. Any i_flag in that cycle is dropped.
- Output: first-word-fall-through.
  - o_valid rises the cycle after the write edge into an empty FIFO.
  - A pop occurs at an edge with o_valid & i_ready.
  - Data and o_valid are stable while o_valid=1 and i_ready=0.
  - Back-to-back pops sustain 1 entry/cycle.
  - o_x/o_y/o_score/o_orient hold their last value when o_valid=0.
- Pointers: log2(DEPTH)+1 bits; wrap at DEPTH. Full = MSB differs and the rest are equal.
- o_kp_count saturates at MAX_KP and holds after the frame until the next i_start.

Optional Feature:
- KP_MIN_SCORE_EN:
  - Defined: keypoints with i_score < MIN_SCORE are silently dropped. They set no sticky flag and are not counted.
  - Undefined: all flagged keypoints are eligible; MIN_SCORE is unused.

Decomposition:
- Shared package: state encodings S_IDLE/S_COLLECT/S_DRAIN, field widths (X_W=10, Y_W=10, SCORE_W=8, ORIENT_W=10), and entry width KP_W=38.
- One sub-module: kp_fifo, a synchronous FWFT FIFO with DEPTH and width parameters, flush input, and full/empty outputs. The controller holds the FSM, counters and flags.

Test Plan:
- Basic frame:
  - Stimulus: i_start; flags at (40,50,s=60,o=3) and (100,200,s=90,o=7); i_end; i_ready=1.
  - Response: two entries out in order; o_kp_count=2; o_frame_done one cycle after the last pop.
- Backpressure:
  - Stimulus: DEPTH=4, i_ready=0, 6 consecutive flags.
  - Response: first 4 stored; o_overflow=1; o_kp_count=4; the head entry stays stable until i_ready=1.
- Cap:
  - Stimulus: MAX_KP=3, 5 flags with i_ready=1.
  - Response: 3 outputs; o_capped=1; o_overflow=0; o_kp_count=3.
- Restart:
  - Stimulus: i_start mid-frame with 2 entries queued.
  - Response: o_valid=0 next cycle; counters cleared; no o_frame_done.
- Edge cases:
  - Stimulus: i_flag and i_end in the same cycle; empty frame.
  - Response: the flagged keypoint is stored, then emitted before o_frame_done. An empty frame gives o_frame_done 2 edges after i_end.
- KP_MIN_SCORE_EN with MIN_SCORE=30:
  - Stimulus: scores 29, 30, 31.
  - Response: 2 outputs (scores 30 and 31); o_kp_count=2.
